reg_arbiter: RTL and testbench
==============================

# reg_arbiter

Round-robin arbiter that shares one `DATAWIDTH`-bit storage register among `NREQ` requesters. Each requester asks for write access with a level request and is granted exclusive ownership for a bounded burst of writes. The block sits in front of a shared state register in a scheduled datapath, replacing a bare register whose `d` input would otherwise need an ad-hoc mux and enable. The stored value, a write strobe and the one-hot grant are all registered outputs.

## Interface
- `DATAWIDTH`, 8, width of stored data and of each requester's data lane.
- `NREQ`, 4, number of requesters; legal range 2..8.
- `MAXHOLD`, 2, maximum writes per grant; legal range 1..15.

- `Clk`  in  1  clock; all state changes on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  level request; bit i belongs to requester i.
- `d`  in  NREQ*DATAWIDTH  flattened data; requester i drives bits [i*DATAWIDTH +: DATAWIDTH].
- `gnt`  out  NREQ  one-hot grant, registered; all-zero when idle.
- `q`  out  DATAWIDTH  stored register value.
- `wr`  out  1  high for one cycle after each edge that updated `q`.

## Operation
- States: IDLE and GRANT. Internal state: owner index, round-robin pointer `ptr` (last released owner) and hold counter `cnt` (width ceil(log2(MAXHOLD+1))).
- Reset (Rst=0, asynchronous): state=IDLE, `gnt`=0, `q`=0, `wr`=0, `cnt`=0, `ptr`=NREQ-1, so requester 0 has first priority.
- IDLE, rising edge with `req`≠0: select the first set bit searching ptr+1, ptr+2, … mod NREQ. Load the owner, set `gnt` one-hot for it, set `cnt`=0 and go to GRANT. No write occurs on this edge. IDLE with `req`=0: hold.
- GRANT, rising edge with `req[owner]`=1:
  - `q` ← d lane of owner; `wr`←1; `cnt`←cnt+1.
  - If cnt+1 = MAXHOLD: also release. Set `gnt`←0, `ptr`←owner, `cnt`←0 and go to IDLE.
- GRANT, rising edge with `req[owner]`=0: release with no write. Set `gnt`←0, `ptr`←owner, go to IDLE, `wr`←0.
- `wr` is 0 on every edge that does not write `q`.
- Requests from non-owners during GRANT are ignored and never write `q`. They are considered at the next IDLE edge.
- `q` holds its value indefinitely between writes. The arbiter performs no arithmetic on data.

## Timing
- Request to grant: `req[i]` seen at edge E in IDLE gives `gnt[i]`=1 after E.
- First write at E+1 if `req[i]` is still high. `q` and `wr` are visible after E+1.
- Burst: a continuously requesting owner writes on MAXHOLD consecutive edges E+1 … E+MAXHOLD. `gnt` drops after the last of these.
- Re-arbitration: exactly one IDLE cycle separates consecutive grants, because `gnt` is all-zero for one full cycle. Back-to-back service of NREQ continuous requesters therefore takes NREQ*(MAXHOLD+1) cycles per rotation.
- Fairness: with all requests held high, grant order is 0,1,…,NREQ-1,0,… A requester waits at most (NREQ-1)*(MAXHOLD+1) cycles between its request being seen in IDLE and its grant.
- Pointer wrap: with `ptr`=NREQ-1, the search starts at 0.
- Simultaneous release and new request from the same requester: that requester is lowest priority at the next IDLE edge.
- Reset mid-GRANT: outputs clear immediately on Rst falling, without waiting for `Clk`. After Rst rises, the first grant follows the reset priority (requester 0 first).
- `gnt` is never multi-hot. `gnt` and `wr` are never X after reset.

## Test plan
- Reset: Rst=0 with `req`=1111 and toggling `Clk` -> `gnt`=0000, `q`=0, `wr`=0 throughout. Release Rst -> `gnt`=0001 one edge later.
- Single requester (NREQ=4, MAXHOLD=2): `req`=0100 held, d lane 2 = 0x0A.
  - `gnt`=0100 after edge 1.
  - `q`=0x0A with `wr`=1 after edges 2 and 3.
  - `gnt`=0000 after edge 3, then `gnt`=0100 again after edge 4.
- Rotation: `req`=1111, lanes 0x11/0x22/0x33/0x44 -> grants 0001, 0010, 0100, 1000, 0001.
  - Each grant is 2 cycles long, with a 1-cycle all-zero gap between grants.
  - `q` follows 0x11,0x11,0x22,0x22,…
- Early drop: owner 1 drops `req` after one write -> `q`=lane 1 value written once, `gnt` clears on the next edge, `wr`=0 on that edge, and requester 2 is granted next.
- Wrap and priority: last owner 3, then `req`=1001 -> `gnt`=0001 (requester 0 before requester 3).
- Async reset mid-burst: assert Rst between edges while `gnt`=0010 -> `gnt`, `q` and `wr` are 0 before the next `Clk` edge. After release with `req`=0010 -> `gnt`=0010 and `q` is rewritten from lane 1.

Source files
------------

// File: rtl/reg_arbiter_if.sv
// reg_arbiter_if: request/data lanes in, grant/stored value/write strobe out
interface reg_arbiter_if #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4
);
    logic [NREQ-1:0]           req;
    logic [NREQ*DATAWIDTH-1:0] d;
    logic [NREQ-1:0]           gnt;
    logic [DATAWIDTH-1:0]      q;
    logic                      wr;
    modport master (output req, d, input gnt, q, wr);
    modport slave  (input req, d, output gnt, q, wr);
endinterface

// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin owner of one shared register, bounded write bursts per grant
module reg_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int MAXHOLD   = 2
) (
    input logic          Clk,
    input logic          Rst,
    reg_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAXHOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        owner, owner_n, ptr, ptr_n, sel;
    logic [CW-1:0]        cnt, cnt_n;
    logic [NREQ-1:0]      gnt, gnt_n;
    logic [DATAWIDTH-1:0] q, q_n;
    logic                 wr, wr_n;

    assign bus.gnt = gnt;
    assign bus.q   = q;
    assign bus.wr  = wr;

    // nearest requester after ptr wins: scan far-to-near so the closest set bit is written last
    always_comb begin
        sel = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[IW'((int'(ptr) + k) % NREQ)]) sel = IW'((int'(ptr) + k) % NREQ);
        end
    end

    // next state: grant on IDLE, write/count/release on GRANT
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        q_n     = q;
        wr_n    = 1'b0;
        if (state == IDLE) begin
            if (|bus.req) begin
                owner_n = sel;
                gnt_n   = NREQ'(1) << sel;
                cnt_n   = '0;
                state_n = GRANT;
            end
        end else if (bus.req[owner]) begin
            q_n  = DATAWIDTH'(bus.d >> (int'(owner) * DATAWIDTH));
            wr_n = 1'b1;
            cnt_n = (cnt == CW'(MAXHOLD - 1)) ? '0 : cnt + CW'(1);
            if (cnt == CW'(MAXHOLD - 1)) begin
                gnt_n   = '0;
                ptr_n   = owner;
                state_n = IDLE;
            end
        end else begin
            gnt_n   = '0;
            ptr_n   = owner;
            cnt_n   = '0;
            state_n = IDLE;
        end
    end

    // state and registered outputs; reset gives requester 0 first priority
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= IW'(NREQ - 1);
            cnt   <= '0;
            gnt   <= '0;
            q     <= '0;
            wr    <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            q     <= q_n;
            wr    <= wr_n;
        end
    end
endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: directed checks of grant order, bursts, early release and async reset
module tb_reg_arbiter;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    reg_arbiter_if #(.DATAWIDTH(8), .NREQ(4)) bus ();
    reg_arbiter #(.DATAWIDTH(8), .NREQ(4), .MAXHOLD(2)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] g, input logic [7:0] q, input logic w);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, ".q"}, 32'(bus.q), 32'(q));
        chk({tag, ".wr"}, 32'(bus.wr), 32'(w));
    endtask

    initial begin
        bus.req = 4'b1111;
        bus.d   = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        chk3("rst0", 4'b0000, 8'h00, 1'b0);
        step();
        chk3("rst1", 4'b0000, 8'h00, 1'b0);
        step();
        chk3("rst2", 4'b0000, 8'h00, 1'b0);
        Rst = 1'b1;
        step();
        chk3("first_gnt", 4'b0001, 8'h00, 1'b0);
        bus.req = 4'b0000;
        step();
        chk3("drop_no_write", 4'b0000, 8'h00, 1'b0);
        // single requester 2, lane 2 = 0x0A
        bus.req = 4'b0100;
        bus.d   = {8'h44, 8'h0A, 8'h22, 8'h11};
        step();
        chk3("single_e1", 4'b0100, 8'h00, 1'b0);
        step();
        chk3("single_e2", 4'b0100, 8'h0A, 1'b1);
        step();
        chk3("single_e3", 4'b0000, 8'h0A, 1'b1);
        step();
        chk3("single_e4", 4'b0100, 8'h0A, 1'b0);
        bus.req = 4'b0000;
        step();
        chk3("single_end", 4'b0000, 8'h0A, 1'b0);
        // async reset pulse between edges restores requester 0 priority
        Rst = 1'b0;
        #1;
        chk3("pulse_rst", 4'b0000, 8'h00, 1'b0);
        Rst = 1'b1;
        bus.req = 4'b1111;
        bus.d   = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            step();
            chk3($sformatf("rot%0d_g", i), 4'(1 << i), (i == 0) ? 8'h00 : 8'(i * 17), 1'b0);
            step();
            chk3($sformatf("rot%0d_w1", i), 4'(1 << i), 8'((i + 1) * 17), 1'b1);
            step();
            chk3($sformatf("rot%0d_w2", i), 4'b0000, 8'((i + 1) * 17), 1'b1);
        end
        step();
        chk3("rot_wrap", 4'b0001, 8'h44, 1'b0);
        step();
        step();
        chk3("rot_wrap_end", 4'b0000, 8'h11, 1'b1);
        // early drop by owner 1 after one write
        step();
        chk3("drop_g", 4'b0010, 8'h11, 1'b0);
        step();
        chk3("drop_w", 4'b0010, 8'h22, 1'b1);
        bus.req = 4'b1101;
        step();
        chk3("drop_rel", 4'b0000, 8'h22, 1'b0);
        step();
        chk3("drop_next", 4'b0100, 8'h22, 1'b0);
        step();
        step();
        step();
        chk3("own3_g", 4'b1000, 8'h33, 1'b0);
        step();
        step();
        chk3("own3_end", 4'b0000, 8'h44, 1'b1);
        // wrap: last owner 3, requester 0 beats requester 3
        bus.req = 4'b1001;
        step();
        chk3("wrap_prio", 4'b0001, 8'h44, 1'b0);
        bus.req = 4'b0011;
        step();
        step();
        chk3("pre_rst_end", 4'b0000, 8'h11, 1'b1);
        step();
        chk3("pre_rst_g", 4'b0010, 8'h11, 1'b0);
        // async reset while requester 1 owns
        #2;
        Rst = 1'b0;
        #1;
        chk3("async_rst", 4'b0000, 8'h00, 1'b0);
        Rst = 1'b1;
        bus.req = 4'b0010;
        step();
        chk3("post_rst_g", 4'b0010, 8'h00, 1'b0);
        step();
        chk3("post_rst_w", 4'b0010, 8'h22, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
